assoc_cache: RTL and testbench
==============================

# assoc_cache

Parametrised two-way set-associative, write-back, write-allocate data cache between the CPU datapath and block-wide main memory. It generalises the direct-mapped, fixed-size cache to configurable word width, set count and block size. The CPU side uses a valid/ready request with a registered response, and the memory side uses a req/ack block handshake with arbitrary latency. Dirty victims are written back before refill.

## Interface
- WORD_SIZE, 16, bits per word and per address
- SETS, 4, number of sets (power of two, ≥2)
- BLOCK_WORDS, 4, words per block (power of two, ≥2)
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- req_valid  in  1  CPU request present
- req_we  in  1  1 = write, 0 = read
- req_addr  in  WORD_SIZE  word address
- req_wdata  in  WORD_SIZE  store data
- req_ready  out  1  cache can accept a request this cycle
- resp_valid  out  1  one-cycle pulse, request complete
- resp_rdata  out  WORD_SIZE  load data; valid only with resp_valid on a read
- mem_req  out  1  memory transaction pending
- mem_we  out  1  1 = block write-back, 0 = block fill
- mem_addr  out  WORD_SIZE  block-aligned address (offset bits zero)
- mem_wdata  out  BLOCK_WORDS*WORD_SIZE  write-back block; word 0 in the MSBs
- mem_rdata  in  BLOCK_WORDS*WORD_SIZE  fill block; word 0 in the MSBs
- mem_ack  in  1  one-cycle pulse, transaction done (fill data valid this cycle)
- hit_count, miss_count  out  WORD_SIZE  statistics (only with CACHE_STATS_EN)

## Operation
- Address split:
  - offset = low log2(BLOCK_WORDS) bits
  - index = next log2(SETS) bits
  - tag = remainder
- Per set: two ways, each with valid, dirty, tag and data; one LRU bit per set naming the next victim.
- FSM states are IDLE, WRBACK, REFILL and RESP.
- IDLE: req_ready=1. A request is accepted on req_valid && req_ready, and address, we and wdata are latched.
  - Hit, read: resp_rdata = the hit word.
  - Hit, write: the word is written, the line is set dirty.
  - On any hit: LRU points to the other way; go to RESP.
  - Miss: choose the victim. An invalid way is preferred, way 0 first if both are invalid; otherwise the LRU way.
  - Miss with victim valid && dirty: go to WRBACK. Otherwise go to REFILL.
- WRBACK: mem_req=1, mem_we=1, mem_addr = {victim tag, index, 0}, mem_wdata = victim data. On mem_ack the victim dirty bit is cleared; go to REFILL.
- REFILL: mem_req=1, mem_we=0, mem_addr = {req tag, index, 0}.
  - On mem_ack: the block is written into the victim way, valid=1, dirty=0, tag updated.
  - For a write, the latched word is then merged and dirty=1.
  - LRU is updated; go to RESP.
- RESP: resp_valid=1 for one cycle; go to IDLE. req_ready=0 in every non-IDLE state.
- mem_req, mem_we, mem_addr and mem_wdata are registered and held stable until mem_ack.
- mem_ack outside WRBACK/REFILL is ignored.
- Reset values: all valid, dirty and LRU bits 0; FSM to IDLE; req_ready=1; resp_valid=0; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; resp_rdata=0; counters 0.
- Reset mid-miss: mem_req drops the next cycle, the transaction is abandoned, and no response is issued. Memory must tolerate a dropped request.

## Timing
- Hit: accepted in cycle N, resp_valid in N+1; next request can be accepted in N+2.
- Clean miss: mem_req rises in N+1. If mem_ack arrives in cycle A, resp_valid is in A+1.
- Dirty miss: write-back ack in A1, fill mem_req in A1+1. Fill ack in A2, resp_valid in A2+1.
- Zero-wait memory (ack the cycle after req) gives a clean-miss latency of 3 cycles.

## Configuration
- CACHE_STATS_EN defined:
  - hit_count and miss_count ports exist.
  - Each increments once per accepted request, in the acceptance cycle.
  - Both saturate at all-ones.
- CACHE_STATS_EN undefined: the ports and counters are absent. Functional behaviour is identical.

## Structure
- Package cache_pkg holds:
  - the state enum {IDLE, WRBACK, REFILL, RESP}
  - localparam functions for OFFSET_W, INDEX_W and TAG_W derived from WORD_SIZE, SETS and BLOCK_WORDS
- Sub-module cache_way_array: one way's storage (valid, dirty, tag, data), with:
  - asynchronous read by index
  - synchronous line write and word-merge write
  - synchronous reset of the valid and dirty bits
- The top level instantiates cache_way_array twice and holds the LRU bits, the FSM and the memory registers.

## Test plan
- Reset, then read 0x0010, memory acks after 5 cycles with block {0xA0,0xA1,0xA2,0xA3} → one fill at mem_addr 0x0010; resp_rdata=0xA0; miss_count=1.
- Read 0x0013 immediately after → hit; resp_valid one cycle after acceptance; rdata=0xA3; no mem_req; hit_count=1.
- Write 0x0011=0xBEEF, then read 0x0011 → both hit; rdata=0xBEEF; no memory traffic.
- With defaults, fill tags at index 0 via 0x0000, 0x0040 and 0x0080 after dirtying 0x0000 → one write-back of the 0x0000 block containing the dirtied word, then a fill of 0x0080. 0x0040 survives (re-read hits).
- Assert reset_n=0 during REFILL → mem_req=0 and req_ready=1 the cycle after reset releases. A read of the same address misses again.
- mem_ack pulse while in IDLE → no state change, no resp_valid.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and address-field width helpers for the two-way associative cache.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRBACK = 2'd1,
        REFILL = 2'd2,
        RESP   = 2'd3
    } state_t;

    function automatic int calc_offset_w(input int block_words);
        return $clog2(block_words);
    endfunction

    function automatic int calc_index_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int calc_tag_w(input int word_size, input int sets, input int block_words);
        return word_size - $clog2(sets) - $clog2(block_words);
    endfunction

endpackage

// File: rtl/cache_way_array.sv
// Storage for one cache way: valid, dirty, tag and block data per set.
module cache_way_array
    import cache_pkg::*;
#(
    parameter int WORD_SIZE   = 16,
    parameter int SETS        = 4,
    parameter int BLOCK_WORDS = 4,
    localparam int OFFSET_W   = calc_offset_w(BLOCK_WORDS),
    localparam int INDEX_W    = calc_index_w(SETS),
    localparam int TAG_W      = calc_tag_w(WORD_SIZE, SETS, BLOCK_WORDS),
    localparam int BLK_W      = BLOCK_WORDS * WORD_SIZE
)
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [INDEX_W-1:0]   rd_index,
    output logic                 rd_valid,
    output logic                 rd_dirty,
    output logic [TAG_W-1:0]     rd_tag,
    output logic [BLK_W-1:0]     rd_data,
    input  logic [INDEX_W-1:0]   wr_index,
    input  logic                 line_we,
    input  logic [TAG_W-1:0]     line_tag,
    input  logic [BLK_W-1:0]     line_data,
    input  logic                 line_dirty,
    input  logic                 word_we,
    input  logic [OFFSET_W-1:0]  word_offset,
    input  logic [WORD_SIZE-1:0] word_data,
    input  logic                 clean_we
);

    logic [SETS-1:0]  valid;
    logic [SETS-1:0]  dirty;
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [BLK_W-1:0] data_mem [SETS];

    assign rd_valid = valid[rd_index];
    assign rd_dirty = dirty[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid <= '0;
            dirty <= '0;
        end else if (line_we) begin
            valid[wr_index] <= 1'b1;
            dirty[wr_index] <= line_dirty;
        end else if (word_we) begin
            dirty[wr_index] <= 1'b1;
        end else if (clean_we) begin
            dirty[wr_index] <= 1'b0;
        end
    end

    // Word 0 lives in the most significant slice of the block.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_mem[wr_index]  <= line_tag;
            data_mem[wr_index] <= line_data;
        end else if (word_we) begin
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                if (word_offset == OFFSET_W'(i))
                    data_mem[wr_index][(BLOCK_WORDS-1-i)*WORD_SIZE +: WORD_SIZE] <= word_data;
            end
        end
    end

endmodule

// File: rtl/assoc_cache.sv
// Two-way set-associative write-back, write-allocate cache with block-wide memory port.
// Optional hit/miss statistics counters are built when CACHE_STATS_EN is defined.
//
// state  | meaning
// IDLE   | ready for a request; hits are serviced here
// WRBACK | writing the dirty victim block back to memory
// REFILL | fetching the requested block into the victim way
// RESP   | one-cycle response pulse
module assoc_cache
    import cache_pkg::*;
#(
    parameter int WORD_SIZE   = 16,
    parameter int SETS        = 4,
    parameter int BLOCK_WORDS = 4,
    localparam int BLK_W      = BLOCK_WORDS * WORD_SIZE
)
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    input  logic                 req_we,
    input  logic [WORD_SIZE-1:0] req_addr,
    input  logic [WORD_SIZE-1:0] req_wdata,
    output logic                 req_ready,
    output logic                 resp_valid,
    output logic [WORD_SIZE-1:0] resp_rdata,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [BLK_W-1:0]     mem_wdata,
    input  logic [BLK_W-1:0]     mem_rdata,
    input  logic                 mem_ack
`ifdef CACHE_STATS_EN
    ,
    output logic [WORD_SIZE-1:0] hit_count,
    output logic [WORD_SIZE-1:0] miss_count
`endif
);

    localparam int OFFSET_W = calc_offset_w(BLOCK_WORDS);
    localparam int INDEX_W  = calc_index_w(SETS);
    localparam int TAG_W    = calc_tag_w(WORD_SIZE, SETS, BLOCK_WORDS);

    state_t state, state_nxt;

    logic [WORD_SIZE-1:0] lat_addr, lat_wdata;
    logic                 lat_we;
    logic                 victim;
    logic [SETS-1:0]      lru;

    logic [OFFSET_W-1:0] req_off, lat_off;
    logic [INDEX_W-1:0]  req_idx, lat_idx, wr_index;
    logic [TAG_W-1:0]    req_tag, lat_tag;

    assign {req_tag, req_idx, req_off} = req_addr;
    assign {lat_tag, lat_idx, lat_off} = lat_addr;

    logic [1:0]       rd_valid, rd_dirty;
    logic [TAG_W-1:0] rd_tag  [2];
    logic [BLK_W-1:0] rd_data [2];
    logic [1:0]       line_we, word_we, clean_we;

    logic                 hit0, hit1, hit, hit_way, miss_victim, victim_dirty;
    logic [TAG_W-1:0]     victim_tag;
    logic [BLK_W-1:0]     hit_data, fill_block;
    logic [WORD_SIZE-1:0] hit_word, fill_word;

    assign hit0         = rd_valid[0] && (rd_tag[0] == req_tag);
    assign hit1         = rd_valid[1] && (rd_tag[1] == req_tag);
    assign hit          = hit0 || hit1;
    assign hit_way      = hit1;
    assign hit_data     = hit_way ? rd_data[1] : rd_data[0];
    // Invalid ways are filled first (way 0 before way 1), then the LRU way.
    assign miss_victim  = !rd_valid[0] ? 1'b0 : (!rd_valid[1] ? 1'b1 : lru[req_idx]);
    assign victim_dirty = rd_valid[miss_victim] && rd_dirty[miss_victim];
    assign victim_tag   = miss_victim ? rd_tag[1] : rd_tag[0];
    assign wr_index     = (state == IDLE) ? req_idx : lat_idx;

    always_comb begin
        hit_word   = '0;
        fill_word  = '0;
        fill_block = mem_rdata;
        for (int i = 0; i < BLOCK_WORDS; i++) begin
            if (req_off == OFFSET_W'(i))
                hit_word = hit_data[(BLOCK_WORDS-1-i)*WORD_SIZE +: WORD_SIZE];
            if (lat_off == OFFSET_W'(i)) begin
                fill_word = mem_rdata[(BLOCK_WORDS-1-i)*WORD_SIZE +: WORD_SIZE];
                if (lat_we)
                    fill_block[(BLOCK_WORDS-1-i)*WORD_SIZE +: WORD_SIZE] = lat_wdata;
            end
        end
    end

    always_comb begin
        for (int w = 0; w < 2; w++) begin
            word_we[w]  = (state == IDLE) && req_valid && hit && req_we && (hit_way == 1'(w));
            line_we[w]  = (state == REFILL) && mem_ack && (victim == 1'(w));
            clean_we[w] = (state == WRBACK) && mem_ack && (victim == 1'(w));
        end
    end

    for (genvar w = 0; w < 2; w++) begin : g_way
        cache_way_array #(
            .WORD_SIZE   (WORD_SIZE),
            .SETS        (SETS),
            .BLOCK_WORDS (BLOCK_WORDS)
        ) u_way (
            .clk         (clk),
            .reset_n     (reset_n),
            .rd_index    (req_idx),
            .rd_valid    (rd_valid[w]),
            .rd_dirty    (rd_dirty[w]),
            .rd_tag      (rd_tag[w]),
            .rd_data     (rd_data[w]),
            .wr_index    (wr_index),
            .line_we     (line_we[w]),
            .line_tag    (lat_tag),
            .line_data   (fill_block),
            .line_dirty  (lat_we),
            .word_we     (word_we[w]),
            .word_offset (req_off),
            .word_data   (req_wdata),
            .clean_we    (clean_we[w])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = hit ? RESP : (victim_dirty ? WRBACK : REFILL);
            WRBACK:  if (mem_ack) state_nxt = REFILL;
            REFILL:  if (mem_ack) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_we     <= 1'b0;
            victim     <= 1'b0;
            lru        <= '0;
            resp_rdata <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_addr  <= req_addr;
                        lat_we    <= req_we;
                        lat_wdata <= req_wdata;
                        if (hit) begin
                            lru[req_idx] <= ~hit_way;
                            if (!req_we) resp_rdata <= hit_word;
                        end else begin
                            victim  <= miss_victim;
                            mem_req <= 1'b1;
                            if (victim_dirty) begin
                                mem_we    <= 1'b1;
                                mem_addr  <= {victim_tag, req_idx, {OFFSET_W{1'b0}}};
                                mem_wdata <= rd_data[miss_victim];
                            end else begin
                                mem_we   <= 1'b0;
                                mem_addr <= {req_tag, req_idx, {OFFSET_W{1'b0}}};
                            end
                        end
                    end
                end
                WRBACK: begin
                    if (mem_ack) begin
                        mem_we   <= 1'b0;
                        mem_addr <= {lat_tag, lat_idx, {OFFSET_W{1'b0}}};
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        mem_req      <= 1'b0;
                        lru[lat_idx] <= ~victim;
                        if (!lat_we) resp_rdata <= fill_word;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if ((state == IDLE) && req_valid) begin
            if (hit && (hit_count != '1))
                hit_count <= hit_count + WORD_SIZE'(1);
            if (!hit && (miss_count != '1))
                miss_count <= miss_count + WORD_SIZE'(1);
        end
    end
`endif

endmodule

// File: tb/tb_assoc_cache.sv
// Directed bench for assoc_cache with a transaction-level cache/memory reference model.
module tb_assoc_cache;

    localparam int W  = 16;
    localparam int S  = 4;
    localparam int B  = 4;
    localparam int BW = B * W;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_valid, req_we;
    logic [W-1:0]  req_addr, req_wdata;
    logic          req_ready, resp_valid;
    logic [W-1:0]  resp_rdata;
    logic          mem_req, mem_we;
    logic [W-1:0]  mem_addr;
    logic [BW-1:0] mem_wdata, mem_rdata;
    logic          mem_ack;
`ifdef CACHE_STATS_EN
    logic [W-1:0]  hit_count, miss_count;
`endif

    assoc_cache #(.WORD_SIZE(W), .SETS(S), .BLOCK_WORDS(B)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
`ifdef CACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Main memory and the reference cache contents
    logic [W-1:0] mem [65536];
    bit           mv [S][2];
    bit           md [S][2];
    int           mt [S][2];
    logic [W-1:0] mw [S][2][B];
    int           mru [S];
    int           n_hit, n_miss;

    typedef struct {
        bit            we;
        logic [W-1:0]  addr;
        logic [BW-1:0] data;
    } txn_t;
    txn_t expq[$];

    // Monitor bookkeeping
    bit            busy, due, exp_we, stray;
    logic [W-1:0]  exp_rdata, last_rdata;
    int            cyc, acc_cyc, latency, acc_cnt, resp_cnt, cnt, mem_delay;
    int            wb_cnt, fill_cnt;
    logic [W-1:0]  last_wb_addr, last_fill_addr, cur_addr;
    logic [BW-1:0] last_wb_data, cur_wdata;
    bit            cur_we;

    function automatic logic [BW-1:0] read_block(input int base);
        logic [BW-1:0] blk;
        for (int i = 0; i < B; i++) blk[(B-1-i)*W +: W] = mem[base + i];
        return blk;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < S; s++) begin
            for (int w = 0; w < 2; w++) begin
                mv[s][w] = 0;
                md[s][w] = 0;
            end
            mru[s] = 1;
        end
        n_hit  = 0;
        n_miss = 0;
    endtask

    task automatic model_access(input bit we, input logic [W-1:0] a, input logic [W-1:0] d);
        int ai, s, t, o, way, v;
        txn_t tx;
        ai = int'(a);
        o  = ai % B;
        s  = (ai / B) % S;
        t  = ai / (B * S);
        way = -1;
        for (int w = 0; w < 2; w++) if (mv[s][w] && mt[s][w] == t) way = w;
        exp_we = we;
        if (way >= 0) begin
            n_hit++;
            if (we) begin
                mw[s][way][o] = d;
                md[s][way]    = 1;
            end else begin
                exp_rdata = mw[s][way][o];
            end
            mru[s] = way;
            due    = 1;
        end else begin
            n_miss++;
            if (!mv[s][0])      v = 0;
            else if (!mv[s][1]) v = 1;
            else                v = 1 - mru[s];
            if (mv[s][v] && md[s][v]) begin
                tx.we   = 1;
                tx.addr = W'(mt[s][v] * B * S + s * B);
                for (int i = 0; i < B; i++) tx.data[(B-1-i)*W +: W] = mw[s][v][i];
                expq.push_back(tx);
            end
            tx.we   = 0;
            tx.addr = W'(t * B * S + s * B);
            tx.data = '0;
            expq.push_back(tx);
            mv[s][v] = 1;
            mt[s][v] = t;
            for (int i = 0; i < B; i++) mw[s][v][i] = mem[t * B * S + s * B + i];
            md[s][v] = we;
            if (we) mw[s][v][o] = d;
            else    exp_rdata = mw[s][v][o];
            mru[s] = v;
        end
    endtask

    // Single compare process: checks outputs, plays memory, feeds the model on acceptance.
    initial begin
        mem_ack   = 0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                model_reset();
                expq.delete();
                busy    = 0;
                due     = 0;
                cnt     = 0;
                mem_ack = 0;
            end else begin
                chk("req_ready", req_ready, !busy);
                chk("resp_valid", resp_valid, due);
                if (due) begin
                    if (!exp_we) chk("resp_rdata", resp_rdata, exp_rdata);
                    last_rdata = resp_rdata;
                    latency    = cyc - acc_cyc;
                    resp_cnt++;
                    busy = 0;
                end
                due = 0;
                chk("mem_req", mem_req, expq.size() != 0);
`ifdef CACHE_STATS_EN
                chk("hit_count", hit_count, n_hit);
                chk("miss_count", miss_count, n_miss);
`endif
                if (mem_ack) begin
                    mem_ack = 0;
                    cnt     = 0;
                end
                if (mem_req) begin
                    if (cnt == 0) begin
                        cur_we    = mem_we;
                        cur_addr  = mem_addr;
                        cur_wdata = mem_wdata;
                        if (expq.size() != 0) begin
                            chk("mem_we", mem_we, expq[0].we);
                            chk("mem_addr", mem_addr, expq[0].addr);
                            if (expq[0].we) chk("mem_wdata", mem_wdata, expq[0].data);
                        end
                    end else begin
                        chk("mem_we_stable", mem_we, cur_we);
                        chk("mem_addr_stable", mem_addr, cur_addr);
                        if (cur_we) chk("mem_wdata_stable", mem_wdata, cur_wdata);
                    end
                    if (cnt == mem_delay) begin
                        mem_ack = 1;
                        if (mem_we) begin
                            for (int i = 0; i < B; i++) mem[int'(mem_addr) + i] = mem_wdata[(B-1-i)*W +: W];
                            wb_cnt++;
                            last_wb_addr = mem_addr;
                            last_wb_data = mem_wdata;
                        end else begin
                            mem_rdata = read_block(int'(mem_addr));
                            fill_cnt++;
                            last_fill_addr = mem_addr;
                            due = 1;
                        end
                        if (expq.size() != 0) void'(expq.pop_front());
                    end else begin
                        cnt++;
                    end
                end else begin
                    cnt = 0;
                end
                if (stray && !mem_req && !mem_ack) begin
                    mem_ack = 1;
                    stray   = 0;
                end
                if (req_valid && req_ready) begin
                    acc_cyc = cyc;
                    acc_cnt++;
                    busy = 1;
                    model_access(req_we, req_addr, req_wdata);
                end
            end
        end
    end

    task automatic access(input bit we, input logic [W-1:0] a, input logic [W-1:0] d, input bit wait_resp);
        int a0, r0, n;
        a0 = acc_cnt;
        r0 = resp_cnt;
        @(posedge clk); #1;
        req_valid = 1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        n = 0;
        while (acc_cnt == a0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        req_valid = 0;
        chk("accepted", acc_cnt - a0, 1);
        if (wait_resp) begin
            n = 0;
            while (resp_cnt == r0 && n < 300) begin
                @(posedge clk); #1;
                n++;
            end
            chk("responded", resp_cnt - r0, 1);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 0;
        @(posedge clk); #1;
        reset_n = 1;
    endtask

    int t0, r0;

    initial begin
        reset_n   = 0;
        req_valid = 0;
        req_we    = 0;
        req_addr  = '0;
        req_wdata = '0;
        stray     = 0;
        mem_delay = 5;
        for (int a = 0; a < 65536; a++) mem[a] = W'(a) ^ 16'hC3C3;
        mem[16'h0010] = 16'h00A0;
        mem[16'h0011] = 16'h00A1;
        mem[16'h0012] = 16'h00A2;
        mem[16'h0013] = 16'h00A3;
        repeat (3) @(posedge clk);
        #1 reset_n = 1;
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_resp_rdata", resp_rdata, 0);

        // Clean miss with a 5-cycle memory
        t0 = fill_cnt;
        access(0, 16'h0010, 16'h0, 1);
        chk("miss_rdata", last_rdata, 16'h00A0);
        chk("miss_fills", fill_cnt - t0, 1);
        chk("miss_fill_addr", last_fill_addr, 16'h0010);
        chk("miss_latency", latency, 7);
`ifdef CACHE_STATS_EN
        chk("miss_count_1", miss_count, 1);
`endif

        // Hits in the same block
        t0 = fill_cnt + wb_cnt;
        access(0, 16'h0013, 16'h0, 1);
        chk("hit_rdata", last_rdata, 16'h00A3);
        chk("hit_latency", latency, 1);
`ifdef CACHE_STATS_EN
        chk("hit_count_1", hit_count, 1);
`endif
        access(1, 16'h0011, 16'hBEEF, 1);
        access(0, 16'h0011, 16'h0, 1);
        chk("wr_hit_rdata", last_rdata, 16'hBEEF);
        chk("hit_no_traffic", fill_cnt + wb_cnt - t0, 0);

        // Dirty victim write-back at index 0
        do_reset();
        access(0, 16'h0000, 16'h0, 1);
        access(1, 16'h0000, 16'h1234, 1);
        access(0, 16'h0040, 16'h0, 1);
        t0 = wb_cnt;
        access(0, 16'h0080, 16'h0, 1);
        chk("wb_count", wb_cnt - t0, 1);
        chk("wb_addr", last_wb_addr, 16'h0000);
        chk("wb_word0", last_wb_data[63:48], 16'h1234);
        chk("wb_word1", last_wb_data[47:32], 16'hC3C2);
        chk("wb_mem", mem[0], 16'h1234);
        chk("wb_fill_addr", last_fill_addr, 16'h0080);
        chk("dirty_latency", latency, 13);
        chk("dirty_rdata", last_rdata, 16'hC343);
        t0 = fill_cnt + wb_cnt;
        access(0, 16'h0040, 16'h0, 1);
        chk("survivor_rdata", last_rdata, 16'hC383);
        chk("survivor_hit", fill_cnt + wb_cnt - t0, 0);

        // Reset while a fill is outstanding
        mem_delay = 10;
        access(0, 16'h0100, 16'h0, 0);
        repeat (3) @(posedge clk);
        #1 chk("refill_pending", mem_req, 1);
        r0 = resp_cnt;
        do_reset();
        #1;
        chk("abort_mem_req", mem_req, 0);
        chk("abort_ready", req_ready, 1);
        chk("abort_no_resp", resp_cnt - r0, 0);
        mem_delay = 1;
        t0 = fill_cnt;
        access(0, 16'h0100, 16'h0, 1);
        chk("remiss_fills", fill_cnt - t0, 1);
        chk("zero_wait_latency", latency, 3);
        chk("remiss_rdata", last_rdata, 16'hC2C3);

        // Stray ack while idle
        r0 = resp_cnt;
        stray = 1;
        repeat (4) @(posedge clk);
        #1;
        chk("stray_no_resp", resp_cnt - r0, 0);
        chk("stray_ready", req_ready, 1);
        access(0, 16'h0101, 16'h0, 1);
        chk("stray_hit_latency", latency, 1);
        chk("stray_hit_rdata", last_rdata, 16'hC2C2);

        // Write miss allocates and merges
        mem_delay = 2;
        access(1, 16'h0025, 16'h5555, 1);
        access(0, 16'h0025, 16'h0, 1);
        chk("wmiss_rdata", last_rdata, 16'h5555);
        access(0, 16'h0024, 16'h0, 1);
        chk("wmiss_neighbour", last_rdata, 16'hC3E7);

        // Conflict traffic on index 1 to exercise LRU and further write-backs
        access(0, 16'h0065, 16'h0, 1);
        access(0, 16'h00A5, 16'h0, 1);
        access(1, 16'h00E6, 16'h7777, 1);
        access(0, 16'h0025, 16'h0, 1);
        chk("reload_merged", last_rdata, 16'h5555);
        access(0, 16'h00E6, 16'h0, 1);
        chk("lru_rdata", last_rdata, 16'h7777);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
